dm_bus_arbiter: RTL and testbench

//  Shares the single data-memory port (m_data_addr/wdata/byteen/rdata) between the CPU M-stage and a secondary master (loader/DMA).

---
 rtl/dm_arb_pkg.sv | 13 +
 rtl/dm_arb_stat_cnt.sv | 22 ++
 rtl/dm_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, idle byte-enable.
package dm_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam logic       OWN_C       = 1'b0;
  localparam logic       OWN_D       = 1'b1;
  localparam logic [3:0] BYTEEN_NONE = 4'b0000;

endpackage

// File: rtl/dm_arb_stat_cnt.sv
// Conflict and CPU-stall event counters for the data-memory arbiter; wrap at 2^32.
// Latency: count visible the cycle after the event. Backpressure: none, pure observer.
module dm_arb_stat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        conflict,
  input  logic        stall,
  output logic [31:0] stat_conflict,
  output logic [31:0] stat_stall
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_conflict <= '0;
      stat_stall    <= '0;
    end else begin
      if (conflict) stat_conflict <= stat_conflict + 32'd1;
      if (stall)    stat_stall    <= stat_stall + 32'd1;
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Shares one data-memory port between CPU M-stage and a secondary master; round-robin plus locked D bursts.
// Latency: grant/mux combinational, D read data registered one cycle. Backpressure: c_stall to CPU, d_gnt to D.
// Optional DM_ARB_STAT_EN adds stat_conflict/stat_stall counter outputs.
module dm_bus_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [3:0]    c_byteen,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_byteen,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_data_addr,
  output logic [DW-1:0] m_data_wdata,
  output logic [3:0]    m_data_byteen,
  input  logic [DW-1:0] m_data_rdata
`ifdef DM_ARB_STAT_EN
  ,
  output logic [31:0]   stat_conflict,
  output logic [31:0]   stat_stall
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          gnt_c, gnt_d;

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
      last  <= OWN_D;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt counts granted burst beats; the beat that reaches MAX_BURST is the last one
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      ARB: begin
        if (gnt_c) begin
          last_nxt = OWN_C;
        end else if (gnt_d) begin
          last_nxt = OWN_D;
          if (d_lock && MAX_BURST > 1) begin
            state_nxt = BURST;
            cnt_nxt   = CW'(1);
          end
        end
      end
      BURST: begin
        if (d_req && d_lock && int'(cnt_inc) < MAX_BURST) begin
          cnt_nxt = cnt_inc;
        end else begin
          state_nxt = ARB;
          cnt_nxt   = '0;
          last_nxt  = OWN_D;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (reset) begin
      case (state)
        ARB: begin
          if (c_req && d_req) begin
            gnt_c = (last == OWN_D);
            gnt_d = (last == OWN_C);
          end else begin
            gnt_c = c_req;
            gnt_d = d_req;
          end
        end
        BURST: begin
          gnt_d = d_req;
          gnt_c = c_req && !d_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_data_addr   = '0;
    m_data_wdata  = '0;
    m_data_byteen = BYTEEN_NONE;
    if (gnt_c) begin
      m_data_addr   = {c_addr[AW-1:2], 2'b00};
      m_data_wdata  = c_wdata;
      m_data_byteen = c_byteen;
    end else if (gnt_d) begin
      m_data_addr   = {d_addr[AW-1:2], 2'b00};
      m_data_wdata  = d_wdata;
      m_data_byteen = d_byteen;
    end
  end

  assign c_stall = reset && c_req && !gnt_c;
  assign d_gnt   = gnt_d;
  assign c_rdata = m_data_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= gnt_d && (d_byteen == BYTEEN_NONE);
      if (gnt_d && (d_byteen == BYTEEN_NONE)) d_rdata <= m_data_rdata;
    end
  end

`ifdef DM_ARB_STAT_EN
  dm_arb_stat_cnt u_stat (
    .clk           (clk),
    .reset         (reset),
    .conflict      (c_req && d_req),
    .stall         (c_stall),
    .stat_conflict (stat_conflict),
    .stat_stall    (stat_stall)
  );
`endif

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter with a behavioural word memory and a D-read scoreboard.
module tb_dm_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, d_req, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_byteen, d_byteen;
  logic [31:0] c_rdata, d_rdata;
  logic        c_stall, d_gnt, d_rvalid;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
`ifdef DM_ARB_STAT_EN
  logic [31:0] stat_conflict, stat_stall;
`endif

  always #5 clk = ~clk;

  dm_bus_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .c_req         (c_req),
    .c_addr        (c_addr),
    .c_wdata       (c_wdata),
    .c_byteen      (c_byteen),
    .c_rdata       (c_rdata),
    .c_stall       (c_stall),
    .d_req         (d_req),
    .d_lock        (d_lock),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_byteen      (d_byteen),
    .d_gnt         (d_gnt),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata)
`ifdef DM_ARB_STAT_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_stall    (stat_stall)
`endif
  );

  // Behavioural data memory: combinational read, byte-lane write on posedge
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2)      return 32'hDEAD_BEEF;
    else if (i == 8) return 32'hC0FF_EE00;
    else             return 32'hA000_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b]) mem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  assign m_data_rdata = mem[m_data_addr[7:2]];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] sb [$];

  always @(negedge clk) begin
    if (d_rvalid) begin
      check("rvalid_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("d_rdata", d_rdata, sb.pop_front());
    end
  end

  task automatic idle_inputs();
    c_req = 1'b0; c_addr = '0; c_wdata = '0; c_byteen = 4'h0;
    d_req = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0; d_byteen = 4'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string pfx, input logic exp_gnt, input logic exp_stall);
    @(negedge clk);
    check({pfx, "_d_gnt"}, 32'(d_gnt), 32'(exp_gnt));
    check({pfx, "_c_stall"}, 32'(c_stall), 32'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic ex_g, ex_s;
    idle_inputs();
    reset = 1'b0;

    // Store held during reset must not reach memory; lands once released
    c_req = 1'b1; c_byteen = 4'hf; c_addr = 32'h10; c_wdata = 32'h1122_3344;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_byteen", 32'(m_data_byteen), 32'd0);
    check("rst_c_stall", 32'(c_stall), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_addr", m_data_addr, 32'd0);
    check("rst_wdata", m_data_wdata, 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("t1_byteen", 32'(m_data_byteen), 32'hf);
    check("t1_addr", m_data_addr, 32'h10);
    check("t1_c_stall", 32'(c_stall), 32'd0);
    next_cycle();
    idle_inputs();
    check("t1_mem", mem[4], 32'h1122_3344);

    // First conflict after reset goes to C, then D
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    c_req = 1'b1; c_addr = 32'h20; d_req = 1'b1; d_addr = 32'h8;
    check_cycle("t2a", 1'b0, 1'b0);
    check("t2a_c_rdata", c_rdata, 32'hC0FF_EE00);
    next_cycle();
    sb.push_back(32'hDEAD_BEEF);
    check_cycle("t2b", 1'b1, 1'b1);
    next_cycle();
    d_req = 1'b0;
    check_cycle("t2c", 1'b0, 1'b0);
    check("t2c_c_rdata", c_rdata, 32'hC0FF_EE00);
    check("t2c_d_rvalid", 32'(d_rvalid), 32'd1);
    next_cycle();
    idle_inputs();

    // Lone D read
    d_req = 1'b1; d_addr = 32'h8;
    sb.push_back(32'hDEAD_BEEF);
    check_cycle("t3a", 1'b1, 1'b0);
    check("t3a_addr", m_data_addr, 32'h8);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t3_rvalid_hi", 32'(d_rvalid), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t3_rvalid_lo", 32'(d_rvalid), 32'd0);
    next_cycle();

    // Locked burst of 4, CPU requests from beat 2 and gets the bus on cycle 5
    for (int k = 0; k < 6; k++) begin
      c_req = (k >= 1 && k < 5); c_addr = 32'h20; c_byteen = 4'h0;
      d_req = 1'b1; d_lock = (k < 5); d_byteen = 4'h0;
      d_addr = 32'h40 + 32'(4 * k);
      ex_g = (k != 4);
      ex_s = (k >= 1 && k <= 3);
      if (ex_g) sb.push_back(32'hA000_0000 | 32'(16 + k));
      check_cycle($sformatf("t4_%0d", k), ex_g, ex_s);
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();

    // C load first so last=C; then conflicting same-word stores
    c_req = 1'b1; c_addr = 32'h20;
    check_cycle("t5pre", 1'b0, 1'b0);
    next_cycle();
    c_req = 1'b1; c_addr = 32'h5; c_byteen = 4'b0010; c_wdata = 32'h0000_5500;
    d_req = 1'b1; d_addr = 32'h4; d_byteen = 4'hf; d_wdata = 32'h1234_5678;
    check_cycle("t5a", 1'b1, 1'b1);
    check("t5a_byteen", 32'(m_data_byteen), 32'hf);
    check("t5a_addr", m_data_addr, 32'h4);
    next_cycle();
    check("t5a_mem", mem[1], 32'h1234_5678);
    d_req = 1'b0; d_byteen = 4'h0;
    check_cycle("t5b", 1'b0, 1'b0);
    check("t5b_byteen", 32'(m_data_byteen), 32'h2);
    check("t5b_addr", m_data_addr, 32'h4);
    next_cycle();
    idle_inputs();
    check("t5b_mem", mem[1], 32'h1234_5578);

    // Ten back-to-back conflicts alternate grants starting with C
    reset = 1'b0;
    @(negedge clk);
`ifdef DM_ARB_STAT_EN
    check("t6_rst_conflict", stat_conflict, 32'd0);
    check("t6_rst_stall", stat_stall, 32'd0);
`endif
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      c_req = 1'b1; c_addr = 32'h20; d_req = 1'b1; d_addr = 32'h8;
      ex_g = (k % 2 == 1);
      if (ex_g) sb.push_back(32'hDEAD_BEEF);
      check_cycle($sformatf("t6_%0d", k), ex_g, ex_g);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
`ifdef DM_ARB_STAT_EN
    check("t6_conflict", stat_conflict, 32'd10);
    check("t6_stall", stat_stall, 32'd5);
    reset = 1'b0;
    #1;
    check("t6_clr_conflict", stat_conflict, 32'd0);
    check("t6_clr_stall", stat_stall, 32'd0);
    next_cycle();
    reset = 1'b1;
`endif

    // Reset in the middle of a locked write burst abandons it
    d_req = 1'b1; d_lock = 1'b1; d_byteen = 4'hf; d_addr = 32'h50; d_wdata = 32'h5555_AAAA;
    check_cycle("t7a", 1'b1, 1'b0);
    next_cycle();
    check_cycle("t7b", 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check("t7_rst_gnt", 32'(d_gnt), 32'd0);
    check("t7_rst_byteen", 32'(m_data_byteen), 32'd0);
    check("t7_rst_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    reset = 1'b1;
    c_req = 1'b1; c_addr = 32'h20;
    check_cycle("t7c", 1'b0, 1'b0);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
